// File: rtl/fp_add_arbiter.sv
// ============================================================================
//  Module   : fp_add_arbiter
//  Purpose  : Round-robin issue sequencer sharing one fixed-latency FP add
//             pipeline; optional per-requester accept counters (ARB_STATS_EN).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fp_add_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 3,
    parameter int TAG_W    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  op_valid,
    output logic [31:0]           op_a,
    output logic [31:0]           op_b,
    output logic [TAG_W-1:0]      op_tag,
    input  logic [31:0]           dp_res,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_data,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy
`ifdef ARB_STATS_EN
    ,
    input  logic [TAG_W-1:0]      stat_sel,
    output logic [15:0]           stat_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TAG_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_outstanding;
    logic [PIPE_LAT-1:0]  r_tp_vld;
    logic [TAG_W-1:0]     r_tp_tag [PIPE_LAT];

    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_found;
    logic [TAG_W-1:0]     w_winner;
    logic                 w_accept;
    logic [31:0]          w_sel_a;
    logic [31:0]          w_sel_b;
    logic                 w_last_vld;
    logic [TAG_W-1:0]     w_last_tag;
    logic                 w_empty;

    // Flush blocks grants in the same cycle it is seen.
    assign w_elig = req_valid & ~r_outstanding
                  & {NUM_REQ{(r_state == ST_RUN) && !flush}};

    always_comb begin : p_grant
        int w_idx;
        w_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = TAG_W'(w_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == TAG_W'(i)) begin
                req_ready[i] = w_found;
                w_sel_a      = req_a[i*32 +: 32];
                w_sel_b      = req_b[i*32 +: 32];
            end
        end
    end

    assign w_accept = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_tag   <= '0;
            r_ptr    <= '0;
        end else begin
            op_valid <= w_accept;
            if (w_accept) begin
                op_a   <= w_sel_a;
                op_b   <= w_sel_b;
                op_tag <= w_winner;
                r_ptr  <= (w_winner == TAG_W'(NUM_REQ - 1)) ? '0 : w_winner + TAG_W'(1);
            end
        end
    end

    // Tag pipe mirrors the datapath latency so the result can be steered home.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tp_vld <= '0;
            for (int s = 0; s < PIPE_LAT; s++) begin
                r_tp_tag[s] <= '0;
            end
        end else begin
            r_tp_vld[0] <= op_valid;
            r_tp_tag[0] <= op_tag;
            for (int s = PIPE_LAT - 1; s > 0; s--) begin
                r_tp_vld[s] <= r_tp_vld[s-1];
                r_tp_tag[s] <= r_tp_tag[s-1];
            end
        end
    end

    assign w_last_vld = r_tp_vld[PIPE_LAT-1];
    assign w_last_tag = r_tp_tag[PIPE_LAT-1];

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (w_last_vld) begin
            rsp_data = dp_res;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_last_tag == TAG_W'(i)) begin
                    rsp_valid[i] = 1'b1;
                end
            end
        end
    end

    // req_ready only ever carries an eligible (hence valid) bit, so it is the accept vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~rsp_valid) | req_ready;
        end
    end

    assign w_empty = !op_valid && (r_tp_vld == '0) && (r_outstanding == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        flush_done  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_RUN;
                    flush_done  = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign busy = (r_state != ST_RUN) || !w_empty;

`ifdef ARB_STATS_EN
    logic [15:0] r_stat [NUM_REQ];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat[i] <= '0;
            end
        end else if (flush_done) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (r_stat[i] != 16'hFFFF)) begin
                    r_stat[i] <= r_stat[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == TAG_W'(i)) begin
                stat_cnt = r_stat[i];
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// ============================================================================
//  Module   : tb_fp_add_arbiter
//  Purpose  : Directed self-checking bench for fp_add_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_add_arbiter;

    logic         clk;
    logic         rstn;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         op_valid;
    logic [31:0]  op_a;
    logic [31:0]  op_b;
    logic [1:0]   op_tag;
    logic [31:0]  dp_res;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         flush;
    logic         flush_done;
    logic         busy;
`ifdef ARB_STATS_EN
    logic [1:0]   stat_sel;
    logic [15:0]  stat_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fp_add_arbiter #(.NUM_REQ(4), .PIPE_LAT(3), .TAG_W(2)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_tag     (op_tag),
        .dp_res     (dp_res),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy)
`ifdef ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: 3-cycle delay; one real FP vector, integer sum otherwise.
    logic [31:0] p_a [3];
    logic [31:0] p_b [3];
    always @(posedge clk) begin
        p_a[0] <= op_a;  p_b[0] <= op_b;
        p_a[1] <= p_a[0]; p_b[1] <= p_b[0];
        p_a[2] <= p_a[1]; p_b[2] <= p_b[1];
    end
    always_comb begin
        if (p_a[2] == 32'h3F80_0000 && p_b[2] == 32'h4000_0000) dp_res = 32'h4040_0000;
        else                                                    dp_res = p_a[2] + p_b[2];
    end

    logic [31:0] exp_sum [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e_rdy;
        logic [3:0] e_rsp;
        rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; flush = 1'b0;
`ifdef ARB_STATS_EN
        stat_sel = '0;
`endif
        #2;
        check("rst_op_valid", op_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_tag", op_tag, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_busy", busy, 0);
        step(); step();
        #3 rstn = 1'b1;

        // Single request from requester 2.
        step();
        req_valid = 4'b0100;
        req_a[95:64] = 32'h3F80_0000;
        req_b[95:64] = 32'h4000_0000;
        #1 check("t1_ready", req_ready, 4'b0100);
        step(); req_valid = '0;
        #1 check("t1_op_valid", op_valid, 1);
        check("t1_op_tag", op_tag, 2);
        check("t1_op_a", op_a, 32'h3F80_0000);
        check("t1_op_b", op_b, 32'h4000_0000);
        step(); #1 check("t1_op_valid_drop", op_valid, 0);
        check("t1_rsp_early2", rsp_valid, 0);
        step(); #1 check("t1_rsp_early3", rsp_valid, 0);
        step(); #1 check("t1_rsp_valid", rsp_valid, 4'b0100);
        check("t1_rsp_data", rsp_data, 32'h4040_0000);
        check("t1_busy", busy, 1);
        step(); #1 check("t1_rsp_gone", rsp_valid, 0);
        check("t1_idle", busy, 0);

        // All four continuously valid, starting from pointer 0.
        rstn = 1'b0; #1 rstn = 1'b1;
        req_a = {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
        req_b = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        for (int k = 0; k < 15; k++) begin
            step();
            req_valid = 4'hF;
            #1;
            e_rdy = (k % 5 == 4) ? 4'd0 : 4'(1 << (k % 5));
            check("rr_ready", req_ready, e_rdy);
            e_rsp = (k >= 4 && ((k - 4) % 5) != 4) ? 4'(1 << ((k - 4) % 5)) : 4'd0;
            check("rr_rsp_valid", rsp_valid, e_rsp);
            if (e_rsp != 0) check("rr_rsp_data", rsp_data, exp_sum[(k - 4) % 5]);
        end
        step(); req_valid = '0;
        step(); step(); step();
        #1 check("rr_drained", busy, 0);

        // Outstanding block on requester 1.
        step(); req_valid = 4'b0010;
        #1 check("ob_first", req_ready, 4'b0010);
        for (int j = 1; j <= 4; j++) begin
            step(); #1 check("ob_blocked", req_ready, 0);
        end
        check("ob_rsp", rsp_valid, 4'b0010);
        step(); #1 check("ob_regrant", req_ready, 4'b0010);
        step(); req_valid = '0;
        step(); step(); step(); step();
        #1 check("ob_drained", busy, 0);

        // Flush with three operations in flight (pointer sits at 2).
        step(); req_valid = 4'b0111;
        #1 check("fl_g0", req_ready, 4'b0100);
        step(); #1 check("fl_g1", req_ready, 4'b0001);
        step(); #1 check("fl_g2", req_ready, 4'b0010);
        step(); req_valid = 4'hF; flush = 1'b1;
        #1 check("fl_nogrant3", req_ready, 0);
        check("fl_fd3", flush_done, 0);
        step(); flush = 1'b0;
        #1 check("fl_nogrant4", req_ready, 0);
        check("fl_rsp4", rsp_valid, 4'b0100);
        check("fl_fd4", flush_done, 0);
        step(); flush = 1'b1;
        #1 check("fl_nogrant5", req_ready, 0);
        check("fl_rsp5", rsp_valid, 4'b0001);
        check("fl_fd5", flush_done, 0);
        step(); flush = 1'b0;
        #1 check("fl_rsp6", rsp_valid, 4'b0010);
        check("fl_fd6", flush_done, 0);
        step(); req_valid = '0;
        #1 check("fl_done", flush_done, 1);
        check("fl_busy7", busy, 1);
        step(); #1 check("fl_fd8", flush_done, 0);
        check("fl_busy8", busy, 0);

        // Flush with nothing in flight.
        step(); flush = 1'b1;
        #1 check("fe_fd0", flush_done, 0);
        step(); flush = 1'b0;
        #1 check("fe_done", flush_done, 1);
        check("fe_busy", busy, 1);
        step(); #1 check("fe_fd2", flush_done, 0);
        check("fe_idle", busy, 0);

        // Reset while two operations are in flight.
        step(); req_valid = 4'b0011;
        #1 check("rs_g0", req_ready, 4'b0001);
        step(); #1 check("rs_g1", req_ready, 4'b0010);
        step(); req_valid = '0;
        #2 rstn = 1'b0;
        #1 check("rs_op_valid", op_valid, 0);
        check("rs_op_a", op_a, 0);
        check("rs_op_b", op_b, 0);
        check("rs_op_tag", op_tag, 0);
        check("rs_rsp_valid", rsp_valid, 0);
        check("rs_rsp_data", rsp_data, 0);
        check("rs_busy", busy, 0);
        step(); #2 rstn = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step(); #1 check("rs_no_rsp", rsp_valid, 0);
        end
        step(); req_valid = 4'hF;
        #1 check("rs_first_grant", req_ready, 4'b0001);
        step(); req_valid = '0;
        for (int j = 0; j < 6; j++) step();

`ifdef ARB_STATS_EN
        step(); req_valid = 4'b1000;
        for (int j = 0; j < 20; j++) step();
        step(); req_valid = '0;
        stat_sel = 2'd3;
        #1 check("st_cnt3", stat_cnt, 5);
        stat_sel = 2'd0;
        #1 check("st_cnt0", stat_cnt, 1);
        for (int j = 0; j < 5; j++) step();
        flush = 1'b1;
        step(); flush = 1'b0;
        step(); step();
        stat_sel = 2'd3;
        #1 check("st_cleared", stat_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
